// File: rtl/param_prom_sequencer.sv
// param_prom_sequencer: reads a header plus NWORDS 16-bit words from a parallel PROM into the parameter register file
module param_prom_sequencer #(
    parameter int          NWORDS  = 16,
    parameter int          CLK_DIV = 4,
    parameter logic [15:0] MAGIC   = 16'hA55A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AL_START,
    input  logic [7:0]  PARAM_DAT_IN,
    output logic        PCLK,
    output logic        PCE,
    output logic        POE,
    output logic [15:0] PRM_WORD,
    output logic [7:0]  PRM_ADDR,
    output logic        PRM_WE,
    output logic        BUSY,
    output logic        AL_DONE,
    output logic [2:0]  AL_STATUS
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    typedef enum logic [2:0] {IDLE, ENA, LOW, HIGH, WR, DONE, ABORT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic          odd;
    logic [7:0]    word_idx;
    logic [7:0]    msb;
    logic          last;
    logic          start;
    logic [15:0]   word;
    assign last  = cnt == CW'(CLK_DIV - 1);
    assign start = state == IDLE && AL_START;
    assign word  = {msb, PARAM_DAT_IN};
    // next-state: phase timing, header check and end-of-load detection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = AL_START ? ENA : IDLE;
            ENA:     state_nx = last ? LOW : ENA;
            LOW:     state_nx = !last ? LOW : !odd ? HIGH : word_idx == 8'd0 ? (word == MAGIC ? HIGH : ABORT) : WR;
            HIGH:    state_nx = last ? LOW : HIGH;
            WR:      state_nx = word_idx == 8'(NWORDS) ? DONE : HIGH;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end
    // phase counter, byte parity, word index and MSB holding register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            odd      <= 1'b0;
            word_idx <= 8'd0;
            msb      <= 8'd0;
        end else begin
            cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
            if (start) begin
                odd      <= 1'b0;
                word_idx <= 8'd0;
            end
            if (state == LOW && last) begin
                odd <= !odd;
                if (!odd) msb <= PARAM_DAT_IN;
                if (odd && word_idx == 8'd0) word_idx <= 8'd1;
            end
            if (state == WR) word_idx <= word_idx + 8'd1;
        end
    end
    // registered pad controls, write port and status, all decoded from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            PCLK      <= 1'b0;
            PCE       <= 1'b0;
            POE       <= 1'b0;
            PRM_WE    <= 1'b0;
            PRM_WORD  <= 16'd0;
            PRM_ADDR  <= 8'd0;
            BUSY      <= 1'b0;
            AL_DONE   <= 1'b0;
            AL_STATUS <= 3'b000;
        end else begin
            PCE    <= state_nx inside {ENA, LOW, HIGH, WR};
            POE    <= state_nx inside {ENA, LOW, HIGH, WR};
            PCLK   <= state_nx == HIGH;
            PRM_WE <= state_nx == WR;
            if (state_nx == WR) begin
                PRM_WORD <= word;
                PRM_ADDR <= word_idx - 8'd1;
            end
            if (start) begin
                BUSY      <= 1'b1;
                AL_DONE   <= 1'b0;
                AL_STATUS <= 3'b100;
            end
            if (state_nx == DONE || state_nx == ABORT) begin
                BUSY      <= 1'b0;
                AL_DONE   <= 1'b1;
                AL_STATUS <= state_nx == DONE ? 3'b001 : 3'b010;
            end
        end
    end
endmodule

// File: tb/tb_param_prom_sequencer.sv
// tb_param_prom_sequencer: directed loads against a PROM model and a scoreboard of expected writes
module tb_param_prom_sequencer;
    localparam int NW  = 4;
    localparam int DIV = 2;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        AL_START = 1'b0;
    logic [7:0]  PARAM_DAT_IN;
    logic        PCLK, PCE, POE, PRM_WE, BUSY, AL_DONE;
    logic [15:0] PRM_WORD;
    logic [7:0]  PRM_ADDR;
    logic [2:0]  AL_STATUS;
    int checks = 0;
    int failures = 0;
    logic [7:0]  rom [0:15];
    logic [3:0]  prom_addr = 4'd0;
    logic        pclk_q = 1'b0;
    int          edges_seen = 0, wr_seen = 0, busy_cyc = 0, done_cnt = 0;
    logic        good = 1'b0;
    logic        mon_pclk = 1'b0, mon_busy = 1'b0;
    logic [15:0] cap_word [0:NW-1];

    param_prom_sequencer #(.NWORDS(NW), .CLK_DIV(DIV), .MAGIC(16'hA55A)) dut (
        .CLK(CLK), .RST(RST), .AL_START(AL_START), .PARAM_DAT_IN(PARAM_DAT_IN),
        .PCLK(PCLK), .PCE(PCE), .POE(POE), .PRM_WORD(PRM_WORD), .PRM_ADDR(PRM_ADDR),
        .PRM_WE(PRM_WE), .BUSY(BUSY), .AL_DONE(AL_DONE), .AL_STATUS(AL_STATUS)
    );

    always #5 CLK = ~CLK;

    // PROM: address counter cleared while disabled, advanced on each PCLK rising edge
    assign PARAM_DAT_IN = rom[prom_addr];
    always @(posedge CLK) begin
        pclk_q    <= PCLK;
        prom_addr <= !PCE ? 4'd0 : (PCLK && !pclk_q) ? prom_addr + 4'd1 : prom_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_rom(input logic [79:0] v);
        for (int i = 0; i < 16; i++) rom[i] = (i < 10) ? v[79-8*i -: 8] : 8'h00;
    endtask

    // per-cycle compare against the scoreboard: write k carries bytes 2k+2,2k+3 at address k
    initial forever begin
        @(negedge CLK);
        chk("poe_eq_pce", POE, PCE);
        chk("pce_eq_busy", PCE, BUSY);
        if (PCLK && !mon_pclk) edges_seen++;
        if (BUSY) busy_cyc++;
        if (!BUSY && mon_busy) done_cnt++;
        if (PRM_WE) begin
            chk("we_allowed", 32'(good && wr_seen < NW), 1);
            if (good && wr_seen < NW) begin
                chk("we_word", PRM_WORD, {rom[2*wr_seen+2], rom[2*wr_seen+3]});
                chk("we_addr", PRM_ADDR, wr_seen);
                cap_word[wr_seen] = PRM_WORD;
            end
            wr_seen++;
        end
        mon_pclk = PCLK;
        mon_busy = BUSY;
    end

    task automatic start_load();
        @(negedge CLK);
        good = {rom[0], rom[1]} == 16'hA55A;
        edges_seen = 0;
        wr_seen = 0;
        busy_cyc = 0;
        done_cnt = 0;
        AL_START = 1'b1;
        @(negedge CLK);
        AL_START = 1'b0;
        chk("start_status", AL_STATUS, 3'b100);
        chk("start_done_clr", AL_DONE, 0);
        chk("start_busy", BUSY, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!AL_DONE && n < 400);
        chk("done_in_time", AL_DONE, 1);
    endtask

    task automatic check_good();
        chk("writes", wr_seen, NW);
        chk("pclk_edges", edges_seen, 2*(NW+1)-1);
        chk("busy_cycles", busy_cyc, DIV*(4*NW+4)+NW);
        chk("status_ok", AL_STATUS, 3'b001);
        chk("done_flag", AL_DONE, 1);
        chk("pce_off", {PCE, POE, PCLK}, 0);
        chk("word_hold", PRM_WORD, {rom[2*NW], rom[2*NW+1]});
        chk("addr_hold", PRM_ADDR, NW-1);
    endtask

    initial begin
        int n;
        set_rom(80'hA55A_1234_5678_9ABC_DEF0);
        // reset
        repeat (3) @(negedge CLK);
        chk("rst_outputs", {PCLK, PCE, POE, PRM_WORD, PRM_ADDR, PRM_WE, BUSY, AL_DONE}, 0);
        chk("rst_status", AL_STATUS, 3'b000);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        // nominal load
        start_load();
        wait_done();
        check_good();
        chk("w0_lit", cap_word[0], 16'h1234);
        chk("w1_lit", cap_word[1], 16'h5678);
        chk("w2_lit", cap_word[2], 16'h9ABC);
        chk("w3_lit", cap_word[3], 16'hDEF0);
        chk("edges_lit", edges_seen, 9);
        chk("busy_lit", busy_cyc, 44);
        // bad header
        repeat (3) @(negedge CLK);
        set_rom(80'hA55B_1111_2222_3333_4444);
        start_load();
        wait_done();
        chk("bad_writes", wr_seen, 0);
        chk("bad_edges", edges_seen, 1);
        chk("bad_status", AL_STATUS, 3'b010);
        chk("bad_done", AL_DONE, 1);
        chk("bad_pce", PCE, 0);
        chk("bad_word_hold", PRM_WORD, 16'hDEF0);
        // start while busy
        repeat (3) @(negedge CLK);
        set_rom(80'hA55A_1234_5678_9ABC_DEF0);
        start_load();
        n = 0;
        while (wr_seen < 2 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_word2", wr_seen, 2);
        AL_START = 1'b1;
        @(negedge CLK);
        AL_START = 1'b0;
        wait_done();
        check_good();
        repeat (3) @(negedge CLK);
        chk("single_done", done_cnt, 1);
        chk("status_hold", AL_STATUS, 3'b001);
        chk("done_hold", AL_DONE, 1);
        // reset during the HIGH phase after byte 4 (byte 5 next)
        start_load();
        n = 0;
        while (!(PCLK && edges_seen == 5) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_byte5", edges_seen, 5);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_pins", {PCE, POE, PCLK, BUSY, PRM_WE}, 0);
        chk("rst_mid_status", AL_STATUS, 3'b000);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("no_we_after_rst", wr_seen, 1);
        start_load();
        wait_done();
        check_good();
        chk("reload_w0", cap_word[0], 16'h1234);
        // back-to-back: start in the idle cycle right after DONE
        start_load();
        wait_done();
        check_good();
        chk("b2b_w0", cap_word[0], 16'h1234);
        chk("b2b_w3", cap_word[3], 16'hDEF0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
